// File: rtl/rs_hs_pipeline_relay_fifo.sv
// Relay-station valid/ready channel: registered forward and backward
// chains feeding a tail FIFO sized to absorb the round-trip grace period.
module rs_hs_pipeline_relay_fifo #(
  parameter int DATA_WIDTH                      = 32,
  parameter int DEPTH                           = 24,
  parameter int PIPELINE_READY_IN_HEAD          = 1,
  parameter int PIPELINE_VALID_AND_DATA_IN_HEAD = 0,
  parameter int BODY_LEVEL                      = 6,
  parameter int EXTRA_PIPELINE_BEFORE_TAIL      = 0,
  parameter int MEM_STYLE                       = 0,
  parameter int GRACE_PERIOD                    = 2 * BODY_LEVEL
                                                + PIPELINE_READY_IN_HEAD
                                                + PIPELINE_VALID_AND_DATA_IN_HEAD
                                                + 2 * EXTRA_PIPELINE_BEFORE_TAIL,
  parameter int REAL_DEPTH                      = GRACE_PERIOD + DEPTH + 4,
  parameter int REAL_ADDR_WIDTH                 = $clog2(REAL_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [REAL_ADDR_WIDTH:0]   occupancy,
  output logic                       overflow
);

  localparam int L_FWD = PIPELINE_VALID_AND_DATA_IN_HEAD
                       + BODY_LEVEL + EXTRA_PIPELINE_BEFORE_TAIL;
  localparam int L_BWD = PIPELINE_READY_IN_HEAD
                       + BODY_LEVEL + EXTRA_PIPELINE_BEFORE_TAIL;
  localparam int AW = REAL_ADDR_WIDTH;
  localparam int OW = REAL_ADDR_WIDTH + 1;

  localparam logic [AW-1:0] LAST_PTR    = AW'(REAL_DEPTH - 1);
  localparam logic [OW-1:0] FULL_OCC    = OW'(REAL_DEPTH);
  localparam logic [OW-1:0] READY_LIMIT = OW'(REAL_DEPTH - GRACE_PERIOD);

  logic                  accept;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ready_raw;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;

  assign accept = in_valid & in_ready;

  if (L_FWD > 0) begin : g_fwd
    logic                  v_q [L_FWD];
    logic [DATA_WIDTH-1:0] d_q [L_FWD];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < L_FWD; i++) v_q[i] <= 1'b0;
      end else begin
        v_q[0] <= accept;
        for (int i = 1; i < L_FWD; i++) v_q[i] <= v_q[i-1];
      end
    end

    // payload only moves alongside a valid word
    always_ff @(posedge clk) begin
      if (accept) d_q[0] <= in_data;
      for (int i = 1; i < L_FWD; i++)
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
    end

    assign wr_en   = v_q[L_FWD-1];
    assign wr_data = d_q[L_FWD-1];
  end else begin : g_fwd_bypass
    assign wr_en   = accept;
    assign wr_data = in_data;
  end

  assign ready_raw = (occ_q < READY_LIMIT);

  if (L_BWD > 0) begin : g_bwd
    logic r_q [L_BWD];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < L_BWD; i++) r_q[i] <= 1'b0;
      end else begin
        r_q[0] <= ready_raw;
        for (int i = 1; i < L_BWD; i++) r_q[i] <= r_q[i-1];
      end
    end

    assign in_ready = r_q[L_BWD-1];
  end else begin : g_bwd_bypass
    assign in_ready = ready_raw & ~reset;
  end

  always_comb begin
    full     = (occ_q == FULL_OCC);
    push     = wr_en & ~full;
    pop      = (occ_q != '0) & out_ready;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | (wr_en & full);
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  if (MEM_STYLE == 1) begin : g_mem_block
    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0] mem_q [REAL_DEPTH];

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign out_data = mem_q[rd_ptr_q];
  end else begin : g_mem_dist
    (* ram_style = "distributed" *)
    logic [DATA_WIDTH-1:0] mem_q [REAL_DEPTH];

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign out_data = mem_q[rd_ptr_q];
  end

  assign out_valid = (occ_q != '0);
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

endmodule
